// File: rtl/game_timer.sv
// Game clock: NUM_DIGITS-digit BCD seconds timer counting LIMIT->0 or 0->LIMIT, with
// start/pause/load control, one-shot expiry, per-second tick and active-low 7-segment decode.
module game_timer #(
  parameter int unsigned CLOCK_FREQUENCY = 50000000,
  parameter int unsigned NUM_DIGITS      = 2,
  parameter bit          COUNT_DOWN      = 1'b1,
  parameter int unsigned LIMIT           = 60
) (
  input  logic                    ClockIn,
  input  logic                    Reset,
  input  logic                    Start,
  input  logic                    Pause,
  input  logic                    Load,
  input  logic [4*NUM_DIGITS-1:0] LoadValue,
  output logic [4*NUM_DIGITS-1:0] BcdValue,
  output logic [7*NUM_DIGITS-1:0] Hex,
  output logic                    Running,
  output logic                    Done,
  output logic                    Expired,
  output logic                    Tick
);

  localparam int unsigned BW = 4 * NUM_DIGITS;
  localparam int unsigned PW = $clog2(CLOCK_FREQUENCY);
  localparam logic [PW-1:0] PreMax = PW'(CLOCK_FREQUENCY - 1);

  function automatic logic [BW-1:0] to_bcd(input int unsigned v);
    logic [BW-1:0] r;
    int unsigned   rem;
    r   = '0;
    rem = v;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      r[4*i +: 4] = 4'(rem % 10);
      rem         = rem / 10;
    end
    return r;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  localparam logic [BW-1:0] LimitBcd = to_bcd(LIMIT);
  localparam logic [BW-1:0] HomeVal  = COUNT_DOWN ? LimitBcd : '0;
  localparam logic [BW-1:0] TermVal  = COUNT_DOWN ? '0 : LimitBcd;

  typedef enum logic [1:0] {StIdle, StRun, StPaused, StDone} state_e;

  state_e        state_q, state_d;
  logic [BW-1:0] value_q, value_d;
  logic [PW-1:0] pre_q, pre_d;
  logic          tick_q, tick_d;
  logic          expired_q, expired_d;

  logic [BW-1:0] step_val;
  logic [BW-1:0] load_clamped;
  logic          carry;
  logic [3:0]    digit;

  // One-second BCD step; the carry/borrow ripples through digits that wrap.
  always_comb begin
    step_val = value_q;
    carry    = 1'b1;
    digit    = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      digit = value_q[4*i +: 4];
      if (carry) begin
        if (COUNT_DOWN) begin
          if (digit == 4'd0) begin
            step_val[4*i +: 4] = 4'd9;
          end else begin
            step_val[4*i +: 4] = digit - 4'd1;
            carry              = 1'b0;
          end
        end else begin
          if (digit >= 4'd9) begin
            step_val[4*i +: 4] = 4'd0;
          end else begin
            step_val[4*i +: 4] = digit + 4'd1;
            carry              = 1'b0;
          end
        end
      end
    end
  end

  always_comb begin
    load_clamped = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      load_clamped[4*i +: 4] = (LoadValue[4*i +: 4] > 4'd9) ? 4'd9 : LoadValue[4*i +: 4];
    end
  end

  always_comb begin
    state_d   = state_q;
    value_d   = value_q;
    pre_d     = pre_q;
    tick_d    = 1'b0;
    expired_d = 1'b0;
    if (Load) begin
      value_d = load_clamped;
      pre_d   = PreMax;
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (Start) begin
            if (value_q != TermVal) begin
              state_d = StRun;
              pre_d   = PreMax;
            end else begin
              state_d   = StDone;
              expired_d = 1'b1;
            end
          end
        end
        StDone: begin
          if (Start) begin
            value_d = HomeVal;
            pre_d   = PreMax;
            state_d = StRun;
          end
        end
        StRun: begin
          // A tick coinciding with Pause still counts; reaching terminal overrides the pause.
          if (Pause) state_d = StPaused;
          if (pre_q == '0) begin
            pre_d   = PreMax;
            tick_d  = 1'b1;
            value_d = step_val;
            if (step_val == TermVal) begin
              state_d   = StDone;
              expired_d = 1'b1;
            end
          end else begin
            pre_d = pre_q - PW'(1);
          end
        end
        StPaused: begin
          if (!Pause) state_d = StRun;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge ClockIn or posedge Reset) begin
    if (Reset) begin
      state_q   <= StIdle;
      value_q   <= HomeVal;
      pre_q     <= PreMax;
      tick_q    <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      value_q   <= value_d;
      pre_q     <= pre_d;
      tick_q    <= tick_d;
      expired_q <= expired_d;
    end
  end

  always_comb begin
    Hex = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      Hex[7*i +: 7] = seg7(value_q[4*i +: 4]);
    end
  end

  assign BcdValue = value_q;
  assign Running  = (state_q == StRun);
  assign Done     = (state_q == StDone);
  assign Expired  = expired_q;
  assign Tick     = tick_q;

endmodule

// File: tb/tb_game_timer.sv
// Bench for game_timer: a down counter (LIMIT=12) and an up counter (LIMIT=60), both with
// CLOCK_FREQUENCY=4, compared every cycle against a decimal seconds model plus directed checks.
module tb_game_timer;

  localparam int CF = 4;
  localparam int MIdle = 0, MRun = 1, MPaused = 2, MDone = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        start_v[2];
  logic        pause_v[2];
  logic        load_v[2];
  logic [7:0]  lv_v[2];
  logic [7:0]  bcd_o[2];
  logic [13:0] hex_o[2];
  logic        run_o[2];
  logic        done_o[2];
  logic        exp_o[2];
  logic        tick_o[2];

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  game_timer #(.CLOCK_FREQUENCY(CF), .NUM_DIGITS(2), .COUNT_DOWN(1'b1), .LIMIT(12)) u_dn (
    .ClockIn(clk), .Reset(rst), .Start(start_v[0]), .Pause(pause_v[0]), .Load(load_v[0]),
    .LoadValue(lv_v[0]), .BcdValue(bcd_o[0]), .Hex(hex_o[0]), .Running(run_o[0]),
    .Done(done_o[0]), .Expired(exp_o[0]), .Tick(tick_o[0])
  );

  game_timer #(.CLOCK_FREQUENCY(CF), .NUM_DIGITS(2), .COUNT_DOWN(1'b0), .LIMIT(60)) u_up (
    .ClockIn(clk), .Reset(rst), .Start(start_v[1]), .Pause(pause_v[1]), .Load(load_v[1]),
    .LoadValue(lv_v[1]), .BcdValue(bcd_o[1]), .Hex(hex_o[1]), .Running(run_o[1]),
    .Done(done_o[1]), .Expired(exp_o[1]), .Tick(tick_o[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int lim_of(input int i);
    return (i == 0) ? 12 : 60;
  endfunction
  function automatic bit down_of(input int i);
    return (i == 0);
  endfunction
  function automatic int term_of(input int i);
    return down_of(i) ? 0 : lim_of(i);
  endfunction
  function automatic int home_of(input int i);
    return down_of(i) ? lim_of(i) : 0;
  endfunction
  function automatic int dec_of(input logic [7:0] b);
    int t, o;
    t = int'(b[7:4]);
    o = int'(b[3:0]);
    if (t > 9) t = 9;
    if (o > 9) o = 9;
    return t * 10 + o;
  endfunction
  function automatic logic [7:0] bcd_of(input int d);
    return 8'((d / 10) * 16 + d % 10);
  endfunction
  function automatic logic [6:0] seg(input int d);
    logic [6:0] tbl [10];
    tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
            7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    return tbl[d];
  endfunction
  function automatic logic [13:0] hex_of(input int d);
    return {seg((d / 10) % 10), seg(d % 10)};
  endfunction

  // Reference: seconds kept as plain decimal integers, prescaler as a cycle countdown.
  int m_state[2];
  int m_val[2];
  int m_pre[2];
  bit m_tick[2];
  bit m_exp[2];

  task automatic model_next(input int i, output int st, output int val, output int pre,
                            output bit tk, output bit ex);
    st  = m_state[i];
    val = m_val[i];
    pre = m_pre[i];
    tk  = 1'b0;
    ex  = 1'b0;
    if (load_v[i]) begin
      val = dec_of(lv_v[i]);
      pre = CF - 1;
      st  = MIdle;
    end else begin
      case (m_state[i])
        MIdle: if (start_v[i]) begin
          if (val != term_of(i)) begin st = MRun; pre = CF - 1; end
          else begin st = MDone; ex = 1'b1; end
        end
        MDone: if (start_v[i]) begin
          val = home_of(i);
          pre = CF - 1;
          st  = MRun;
        end
        MRun: begin
          if (pre == 0) begin
            pre = CF - 1;
            tk  = 1'b1;
            val = down_of(i) ? val - 1 : val + 1;
            if (val == term_of(i)) begin st = MDone; ex = 1'b1; end
          end else begin
            pre = pre - 1;
          end
          if (st == MRun && pause_v[i]) st = MPaused;
        end
        default: if (!pause_v[i]) st = MRun;
      endcase
    end
  endtask

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 2; i++) begin
      int ns, nv, np;
      bit nt, ne;
      if (rst) begin
        m_state[i] <= MIdle;
        m_val[i]   <= home_of(i);
        m_pre[i]   <= CF - 1;
        m_tick[i]  <= 1'b0;
        m_exp[i]   <= 1'b0;
      end else begin
        model_next(i, ns, nv, np, nt, ne);
        m_state[i] <= ns;
        m_val[i]   <= nv;
        m_pre[i]   <= np;
        m_tick[i]  <= nt;
        m_exp[i]   <= ne;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        string p;
        p = (i == 0) ? "dn" : "up";
        check({p, "_bcd"}, 32'(bcd_o[i]), 32'(bcd_of(m_val[i])));
        check({p, "_hex"}, 32'(hex_o[i]), 32'(hex_of(m_val[i])));
        check({p, "_running"}, 32'(run_o[i]), 32'(m_state[i] == MRun));
        check({p, "_done"}, 32'(done_o[i]), 32'(m_state[i] == MDone));
        check({p, "_expired"}, 32'(exp_o[i]), 32'(m_exp[i]));
        check({p, "_tick"}, 32'(tick_o[i]), 32'(m_tick[i]));
      end
    end
  end

  task automatic pulse_start(input int i);
    start_v[i] = 1'b1;
    @(negedge clk);
    start_v[i] = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int tc, ec, exp_at;
    for (int i = 0; i < 2; i++) begin
      start_v[i] = 1'b0;
      pause_v[i] = 1'b0;
      load_v[i]  = 1'b0;
      lv_v[i]    = 8'h00;
    end
    #2 rst = 1'b1;
    @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_bcd_dn", 32'(bcd_o[0]), 32'h12);
    check("rst_bcd_up", 32'(bcd_o[1]), 32'h00);
    check("rst_hex_dn", 32'(hex_o[0]), 32'({7'b1111001, 7'b0100100}));
    check("rst_hex_up", 32'(hex_o[1]), 32'({7'b1000000, 7'b1000000}));
    check("rst_running", 32'({run_o[0], run_o[1]}), 32'h0);
    check("rst_flags", 32'({done_o[0], exp_o[0], tick_o[0], done_o[1], exp_o[1], tick_o[1]}),
          32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Full down run from 12
    pulse_start(0);
    check("dn_run_at_k", 32'(run_o[0]), 32'h1);
    tc = 0; ec = 0; exp_at = -1;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (tick_o[0]) begin
        tc++;
        check("dn_seq", 32'(bcd_o[0]), 32'(bcd_of(12 - tc)));
      end
      if (exp_o[0]) begin
        ec++;
        if (exp_at < 0) exp_at = n;
      end
    end
    check("dn_ticks", 32'(tc), 32'd12);
    check("dn_expired_cnt", 32'(ec), 32'd1);
    check("dn_expired_cycle", 32'(exp_at), 32'd48);
    check("dn_done", 32'(done_o[0]), 32'h1);
    check("dn_final", 32'(bcd_o[0]), 32'h00);
    check("dn_hex0", 32'(hex_o[0][6:0]), 32'(7'b1000000));

    // Full up run to 60, then 40 more cycles in DONE
    pulse_start(1);
    tc = 0; ec = 0; exp_at = -1;
    for (int n = 1; n <= 280; n++) begin
      @(negedge clk);
      if (tick_o[1]) tc++;
      if (exp_o[1]) begin
        ec++;
        if (exp_at < 0) exp_at = n;
      end
    end
    check("up_ticks", 32'(tc), 32'd60);
    check("up_expired_cnt", 32'(ec), 32'd1);
    check("up_expired_cycle", 32'(exp_at), 32'd240);
    check("up_final", 32'(bcd_o[1]), 32'h60);
    check("up_done", 32'(done_o[1]), 32'h1);

    // Pause after 6 RUN cycles, held 10, released
    pulse_start(0);
    repeat (5) @(negedge clk);
    pause_v[0] = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check("ps_running", 32'(run_o[0]), 32'h0);
      check("ps_frozen", 32'(bcd_o[0]), 32'h11);
      check("ps_notick", 32'(tick_o[0]), 32'h0);
    end
    pause_v[0] = 1'b0;
    @(negedge clk);
    check("ps_resume_run", 32'(run_o[0]), 32'h1);
    check("ps_resume_t1", 32'(tick_o[0]), 32'h0);
    @(negedge clk);
    check("ps_resume_t2", 32'(tick_o[0]), 32'h0);
    @(negedge clk);
    check("ps_resume_tick", 32'(tick_o[0]), 32'h1);
    check("ps_resume_bcd", 32'(bcd_o[0]), 32'h10);

    // Load 0x9F while running
    load_v[0] = 1'b1;
    lv_v[0]   = 8'h9F;
    @(negedge clk);
    load_v[0] = 1'b0;
    check("ld_bcd", 32'(bcd_o[0]), 32'h99);
    check("ld_idle", 32'({run_o[0], done_o[0], tick_o[0]}), 32'h0);
    repeat (6) begin
      @(negedge clk);
      check("ld_hold", 32'({bcd_o[0], tick_o[0]}), 32'({8'h99, 1'b0}));
    end
    pulse_start(0);
    repeat (3) @(negedge clk);
    check("ld_pre_tick", 32'({bcd_o[0], tick_o[0]}), 32'({8'h99, 1'b0}));
    @(negedge clk);
    check("ld_first_tick", 32'({bcd_o[0], tick_o[0]}), 32'({8'h98, 1'b1}));

    // Load 0 then Start: immediate expiry
    load_v[0] = 1'b1;
    lv_v[0]   = 8'h00;
    @(negedge clk);
    load_v[0] = 1'b0;
    pulse_start(0);
    check("z_expired", 32'({exp_o[0], done_o[0], tick_o[0], run_o[0]}), 32'b1100);
    @(negedge clk);
    check("z_after", 32'({exp_o[0], done_o[0], tick_o[0]}), 32'b010);

    // Async reset mid-run
    pulse_start(0);
    repeat (9) @(negedge clk);
    check("ar_before", 32'(bcd_o[0]), 32'h10);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("ar_bcd_dn", 32'(bcd_o[0]), 32'h12);
    check("ar_run_dn", 32'(run_o[0]), 32'h0);
    check("ar_bcd_up", 32'(bcd_o[1]), 32'h00);
    check("ar_done_up", 32'(done_o[1]), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    pulse_start(0);
    repeat (4) @(negedge clk);
    check("ar_rerun", 32'({bcd_o[0], tick_o[0]}), 32'({8'h11, 1'b1}));

    // Randomised commands on both timers
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < 2; i++) begin
        start_v[i] = ($urandom_range(0, 9) == 0);
        if ($urandom_range(0, 7) == 0) pause_v[i] = ~pause_v[i];
        load_v[i] = ($urandom_range(0, 39) == 0);
        lv_v[i]   = 8'($urandom);
      end
      lv_v[1][7:4] = 4'($urandom_range(0, 5));
      @(negedge clk);
    end
    for (int i = 0; i < 2; i++) begin
      start_v[i] = 1'b0;
      pause_v[i] = 1'b0;
      load_v[i]  = 1'b0;
    end
    @(negedge clk);
    chk_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/game_timer.md
# game_timer

Parametrised game-clock block: a seconds timer over `NUM_DIGITS` BCD digits, counting down from `LIMIT` to 0 or up from 0 to `LIMIT`. It supports start, pause, load and a one-shot expiry pulse. It stops cleanly at its terminal value and drives active-low seven-segment patterns for every digit. It sits between the game-control FSM (Start/Pause/Load, Expired) and the HEX displays. It replaces the fixed two-digit, free-running time display.

## Interface
- `CLOCK_FREQUENCY`, default 50000000: ClockIn cycles per second tick; must be ≥ 2.
- `NUM_DIGITS`, default 2: number of BCD digits, range 1–8.
- `COUNT_DOWN`, default 1: 1 counts LIMIT→0; 0 counts 0→LIMIT.
- `LIMIT`, default 60: start value (down mode) or end value (up mode); must be ≤ 10^NUM_DIGITS − 1.

- `ClockIn`, input, 1 bit: the single clock.
- `Reset`, input, 1 bit: asynchronous, active-high reset.
- `Start`, input, 1 bit: level-sampled each cycle; starts or restarts the timer.
- `Pause`, input, 1 bit: level; while high, a running timer holds.
- `Load`, input, 1 bit: single-cycle strobe; loads `LoadValue`.
- `LoadValue`, input, 4·NUM_DIGITS bits: BCD value; digit i occupies [4i+3:4i].
- `BcdValue`, output, 4·NUM_DIGITS bits: current time in BCD.
- `Hex`, output, 7·NUM_DIGITS bits: segment pattern per digit; digit i occupies [7i+6:7i]; active-low; bit0 = segment a … bit6 = segment g.
- `Running`, output, 1 bit: high in RUN.
- `Done`, output, 1 bit: high in DONE.
- `Expired`, output, 1 bit: one-cycle pulse on reaching the terminal value.
- `Tick`, output, 1 bit: one-cycle pulse for each counted second.

## Operation
**States**
- IDLE: after reset or Load; value held.
- RUN: prescaler active.
- PAUSED: value and prescaler frozen.
- DONE: terminal value reached; value held.

**Reset values**
- State IDLE.
- BcdValue = LIMIT (down mode) or 0 (up mode).
- Prescaler = CLOCK_FREQUENCY−1.
- Running, Done, Expired and Tick = 0.
- Hex = pattern for the reset BcdValue.

**Command priority (same cycle):** Load > Start > Pause.
- Load, any state: BcdValue ← LoadValue with each digit > 9 clamped to 9; prescaler reloaded; state → IDLE.
- Start in IDLE:
  - If BcdValue ≠ terminal: → RUN with prescaler reloaded.
  - If BcdValue = terminal: → DONE with an Expired pulse.
- Start in DONE: BcdValue ← reset value; prescaler reloaded; → RUN.
- Start in RUN or PAUSED: ignored.
- Pause high in RUN: → PAUSED. Pause low in PAUSED: → RUN.
  - Prescaler keeps its count across the pause, so partial seconds are preserved.

**Prescaler (RUN only)**
- Width $clog2(CLOCK_FREQUENCY).
- Decrements each cycle; at 0 it reloads CLOCK_FREQUENCY−1 and asserts Tick.

**On Tick**
- Down mode: BCD decrement with borrow; digit 0 → 9 borrows from the next digit.
- Up mode: BCD increment with carry; digit 9 → 0 carries into the next digit.
- If the new value equals the terminal value (0 down / LIMIT up): state → DONE and Expired pulses.
- Values never wrap past the terminal value. No underflow below 0; no overflow past LIMIT.
- Tick on a cycle where Pause is high: the tick counts; the pause takes effect from the next cycle.

**Hex:** combinational decode of each BcdValue digit, standard 0–F active-low patterns (0 → 7'b1000000, 1 → 7'b1111001, 9 → 7'b0010000).

## Timing
- Start sampled at edge k → Running = 1 from edge k.
- First Tick at edge k+CLOCK_FREQUENCY; subsequent ticks every CLOCK_FREQUENCY cycles while running.
- BcdValue updates on the same edge as Tick.
- Expired, Done and the terminal BcdValue all become visible on the same edge. Expired is high for exactly one cycle.
- Load is effective on the next edge. Load in RUN aborts the current second.
- Async Reset mid-count forces the reset values immediately; outputs stay in reset until deassertion. The first edge after deassertion obeys normal rules.
- Over a full run from LIMIT: exactly LIMIT Tick pulses, one Expired pulse, no extra ticks in DONE.

## Test plan
All scenarios use CLOCK_FREQUENCY=4.
- Down, NUM_DIGITS=2, LIMIT=12, Start 1 cycle → BcdValue shows 0x12, 0x11, 0x10, 0x09 … 0x00 at 4-cycle spacing. Borrow occurs at 0x10 → 0x09. Expired pulses once at 0x00 after 48 cycles. Done=1. Hex digit0 = 7'b1000000.
- Up, LIMIT=60 → value climbs 0x00 → 0x60, stops with Done=1; no wrap to 0x61 or 0x00 over a further 40 cycles; 60 Tick pulses total.
- Pause after 6 cycles of RUN, held 10 cycles, then released → first tick arrives 2 cycles after release. Running=0 throughout the pause. BcdValue is frozen.
- Load 0x9F (digit 0 invalid) while in RUN → BcdValue = 0x99; state IDLE; no Tick. Start → 0x98 after 4 cycles.
- Load 0x00 in down mode, then Start → DONE and a single Expired pulse on the next edge; no Tick.
- Reset asserted mid-run, asynchronously between edges → BcdValue = LIMIT and Running = 0 before the next edge. Start after release reruns from the full count.
